// File: rtl/pipelined_barrel_shifter.sv
// Two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR) with valid/ready handshaking.
// Optional carry_out port and pipeline enabled by defining BARREL_SHIFTER_CARRY_EN.
module pipelined_barrel_shifter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [1:0]             shift_type,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_out
`ifdef BARREL_SHIFTER_CARRY_EN
    ,
    output logic                   carry_out
`endif
);

    localparam int unsigned LO_W = SHAMT_WIDTH / 2;
    localparam int unsigned HI_W = SHAMT_WIDTH - LO_W;
    localparam logic [SHAMT_WIDTH:0] DW_S = (SHAMT_WIDTH + 1)'(DATA_WIDTH);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Shift by an arbitrary amount; composing two shifts equals one shift by the sum.
    function automatic logic [DATA_WIDTH-1:0] shift_data(
        input logic [DATA_WIDTH-1:0]  d,
        input logic [1:0]             mode,
        input logic [SHAMT_WIDTH-1:0] amt
    );
        logic [DATA_WIDTH-1:0] r;
        r = d;
        case (mode)
            MODE_LSL: r = d << amt;
            MODE_LSR: r = d >> amt;
            MODE_ASR: r = DATA_WIDTH'($signed(d) >>> amt);
            MODE_ROR: r = (d >> amt) | (d << (DW_S - {1'b0, amt}));
            default:  r = d;
        endcase
        return r;
    endfunction

`ifdef BARREL_SHIFTER_CARRY_EN
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    // Last bit shifted out; masks collapse to zero when amt is 0.
    function automatic logic shift_carry(
        input logic [DATA_WIDTH-1:0]  d,
        input logic [1:0]             mode,
        input logic [SHAMT_WIDTH-1:0] amt,
        input logic [DATA_WIDTH-1:0]  res
    );
        logic c;
        c = 1'b0;
        case (mode)
            MODE_LSL:           c = |(d & (ONE << (DW_S - {1'b0, amt})));
            MODE_LSR, MODE_ASR: c = |(d & ((ONE << amt) >> 1));
            default:            c = (amt != '0) & res[DATA_WIDTH-1];
        endcase
        return c;
    endfunction
`endif

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [1:0]            s1_type;
    logic [HI_W-1:0]       s1_hi;
    logic                  s2_adv;

    logic [SHAMT_WIDTH-1:0] lo_amt;
    logic [SHAMT_WIDTH-1:0] hi_amt;
    logic [DATA_WIDTH-1:0]  s1_next;
    logic [DATA_WIDTH-1:0]  s2_next;

    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;

    assign lo_amt  = SHAMT_WIDTH'(shamt[LO_W-1:0]);
    assign hi_amt  = {s1_hi, {LO_W{1'b0}}};
    assign s1_next = shift_data(data_in, shift_type, lo_amt);
    assign s2_next = shift_data(s1_data, s1_type, hi_amt);

`ifdef BARREL_SHIFTER_CARRY_EN
    logic s1_carry;
    logic s1_carry_next;
    logic s2_carry_next;

    assign s1_carry_next = shift_carry(data_in, shift_type, lo_amt, s1_next);
    // With no high-half shift the result and carry come straight from stage 1.
    assign s2_carry_next = (s1_hi != '0) ? shift_carry(s1_data, s1_type, hi_amt, s2_next)
                                         : s1_carry;
`endif

    // Stage 1 valid and payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_data <= s1_next;
            s1_type <= shift_type;
            s1_hi   <= shamt[SHAMT_WIDTH-1:LO_W];
`ifdef BARREL_SHIFTER_CARRY_EN
            s1_carry <= s1_carry_next;
`endif
        end
    end

    // Stage 2 drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
`ifdef BARREL_SHIFTER_CARRY_EN
            carry_out <= 1'b0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= s2_next;
`ifdef BARREL_SHIFTER_CARRY_EN
                carry_out <= s2_carry_next;
`endif
            end
        end
    end

endmodule
